// File: rtl/intr_pkg.sv
// rtl/intr_pkg.sv - shared types, defaults and priority helper for intr_ctrl
package intr_pkg;

  localparam int MAX_INTR       = 32;
  localparam int IDX_W_MAX      = 5;
  localparam int N_INTR_DEF     = 8;
  localparam int PC_W_DEF       = 10;
  localparam int VEC_BASE_DEF   = 1008;
  localparam int VEC_STRIDE_DEF = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [IDX_W_MAX-1:0] idx;
  } lowest_t;

  // Lowest index wins: index 0 is the highest priority.
  function automatic lowest_t lowest_set(input logic [MAX_INTR-1:0] vec);
    lowest_t r;
    r.valid = 1'b0;
    r.idx   = '0;
    for (int i = MAX_INTR - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.valid = 1'b1;
        r.idx   = IDX_W_MAX'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/intr_sync.sv
// rtl/intr_sync.sv - per-line 3-flop synchroniser with rising-edge detect
module intr_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);

  logic [W-1:0] s1, s2, s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - vectored, nesting, priority interrupt controller
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int N_INTR     = N_INTR_DEF,
  parameter int PC_W       = PC_W_DEF,
  parameter int VEC_BASE   = VEC_BASE_DEF,
  parameter int VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_INTR-1:0] intr,
  input  logic              mask_we,
  input  logic [N_INTR-1:0] mask_wd,
  input  logic              gie_set,
  input  logic              gie_clr,
  input  logic              ack,
  input  logic              reti,
  output logic              irq,
  output logic [PC_W-1:0]   vec_addr,
  output logic [N_INTR-1:0] pending,
  output logic [N_INTR-1:0] in_service,
  output logic              s_intr,
  output logic              overrun,
  output logic              spurious_reti
);

  localparam int CH_W = (N_INTR > 1) ? $clog2(N_INTR) : 1;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   ch;
  logic [N_INTR-1:0] rise;
  logic [N_INTR-1:0] mask;
  logic [N_INTR-1:0] below_mask;
  logic [N_INTR-1:0] eligible;
  logic [N_INTR-1:0] ack_vec;
  logic [N_INTR-1:0] pending_nxt;
  logic [N_INTR-1:0] in_service_nxt;
  logic              gie;
  logic              load;
  logic              accept;
  lowest_t           is_low;
  lowest_t           el_low;

  intr_sync #(.W(N_INTR)) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (intr),
    .rise  (rise)
  );

  // Only channels of strictly higher priority than the innermost in-service one may nest.
  always_comb begin
    is_low     = lowest_set(MAX_INTR'(in_service));
    below_mask = '1;
    if (is_low.valid) begin
      below_mask = N_INTR'((MAX_INTR'(1) << is_low.idx) - MAX_INTR'(1));
    end
    eligible = pending & mask & below_mask;
    el_low   = lowest_set(MAX_INTR'(eligible));
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (gie && !gie_clr && el_low.valid) begin
          state_nxt = ST_REQ;
          load      = 1'b1;
        end
      end
      ST_REQ: begin
        if (ack) begin
          state_nxt = ST_IDLE;
          accept    = 1'b1;
        end else if (gie_clr) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A new edge outranks the ack clear; reti retires before ack commits.
  always_comb begin
    ack_vec        = accept ? (N_INTR'(1) << ch) : '0;
    pending_nxt    = (pending & ~ack_vec) | rise;
    in_service_nxt = in_service;
    if (reti && is_low.valid) begin
      in_service_nxt = in_service & ~(N_INTR'(MAX_INTR'(1) << is_low.idx));
    end
    in_service_nxt = in_service_nxt | ack_vec;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      ch            <= '0;
      vec_addr      <= PC_W'(VEC_BASE);
      pending       <= '0;
      in_service    <= '0;
      mask          <= '1;
      gie           <= 1'b0;
      overrun       <= 1'b0;
      spurious_reti <= 1'b0;
    end else begin
      state         <= state_nxt;
      pending       <= pending_nxt;
      in_service    <= in_service_nxt;
      spurious_reti <= reti && (in_service == '0);
      if (|(rise & pending)) begin
        overrun <= 1'b1;
      end
      if (mask_we) begin
        mask <= mask_wd;
      end
      if (gie_clr) begin
        gie <= 1'b0;
      end else if (gie_set) begin
        gie <= 1'b1;
      end
      if (load) begin
        ch       <= el_low.idx[CH_W-1:0];
        vec_addr <= PC_W'(VEC_BASE + int'(el_low.idx) * VEC_STRIDE);
      end
    end
  end

  assign irq    = (state == ST_REQ);
  assign s_intr = |in_service;

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - directed self-checking bench for intr_ctrl
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] intr;
  logic       mask_we;
  logic [7:0] mask_wd;
  logic       gie_set;
  logic       gie_clr;
  logic       ack;
  logic       reti;
  logic       irq;
  logic [9:0] vec_addr;
  logic [7:0] pending;
  logic [7:0] in_service;
  logic       s_intr;
  logic       overrun;
  logic       spurious_reti;

  int errors = 0;
  int checks = 0;

  intr_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .intr          (intr),
    .mask_we       (mask_we),
    .mask_wd       (mask_wd),
    .gie_set       (gie_set),
    .gie_clr       (gie_clr),
    .ack           (ack),
    .reti          (reti),
    .irq           (irq),
    .vec_addr      (vec_addr),
    .pending       (pending),
    .in_service    (in_service),
    .s_intr        (s_intr),
    .overrun       (overrun),
    .spurious_reti (spurious_reti)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_irq(input int max_cycles, output bit seen);
    seen = irq;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      tick();
      seen = irq;
    end
  endtask

  task automatic do_ack();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic do_reti();
    reti = 1'b1; tick(); reti = 1'b0;
  endtask

  task automatic do_gie_set();
    gie_set = 1'b1; tick(); gie_set = 1'b0;
  endtask

  task automatic do_gie_clr();
    gie_clr = 1'b1; tick(); gie_clr = 1'b0;
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_wd = m; mask_we = 1'b1; tick(); mask_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; intr = '0; mask_we = 0; mask_wd = '0;
    gie_set = 0; gie_clr = 0; ack = 0; reti = 0;
    tick(2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    checks++; if (vec_addr !== 10'd1008) begin errors++; $display("FAIL reset_vec: got %0d want 1008", vec_addr); end
    checks++; if (pending !== 8'h00 || in_service !== 8'h00) begin errors++; $display("FAIL reset_state: pending=%h in_service=%h want 00 00", pending, in_service); end
    checks++; if (s_intr !== 1'b0 || overrun !== 1'b0 || spurious_reti !== 1'b0) begin errors++; $display("FAIL reset_flags: s_intr=%b overrun=%b spurious=%b want 000", s_intr, overrun, spurious_reti); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit seen;
    do_gie_set();
    intr[5] = 1'b1;
    tick(3);
    checks++; if (pending !== 8'h20) begin errors++; $display("FAIL single_pending_e3: got %h want 20", pending); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_irq_e3: got %b want 0", irq); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL single_irq_e4: got %b want 1", irq); end
    checks++; if (vec_addr !== 10'd1018) begin errors++; $display("FAIL single_vec: got %0d want 1018", vec_addr); end
    do_ack();
    checks++; if (irq !== 1'b0 || in_service !== 8'h20 || s_intr !== 1'b1) begin errors++; $display("FAIL single_ack: irq=%b in_service=%h s_intr=%b want 0 20 1", irq, in_service, s_intr); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL single_pending_clr: got %h want 00", pending); end
    do_reti();
    checks++; if (in_service !== 8'h00 || s_intr !== 1'b0) begin errors++; $display("FAIL single_reti: in_service=%h s_intr=%b want 00 0", in_service, s_intr); end
    intr[5] = 1'b0;
    tick(4);
    wait_irq(0, seen);
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL single_no_rerequest: got irq 1 want 0"); end
  endtask

  task automatic test_simultaneous();
    bit seen;
    intr[3] = 1'b1; intr[1] = 1'b1;
    wait_irq(8, seen);
    checks++; if (seen !== 1'b1 || vec_addr !== 10'd1010) begin errors++; $display("FAIL simul_first: irq=%b vec=%0d want 1 1010", seen, vec_addr); end
    do_ack();
    checks++; if (in_service !== 8'h02 || pending !== 8'h08) begin errors++; $display("FAIL simul_ack1: in_service=%h pending=%h want 02 08", in_service, pending); end
    tick(4);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL simul_blocked: irq=%b want 0", irq); end
    do_reti();
    wait_irq(4, seen);
    checks++; if (seen !== 1'b1 || vec_addr !== 10'd1014) begin errors++; $display("FAIL simul_second: irq=%b vec=%0d want 1 1014", seen, vec_addr); end
    do_ack();
    do_reti();
    intr = '0;
    tick(4);
  endtask

  task automatic test_nesting();
    bit seen;
    intr[4] = 1'b1;
    wait_irq(8, seen);
    do_ack();
    checks++; if (in_service !== 8'h10) begin errors++; $display("FAIL nest_outer: in_service=%h want 10", in_service); end
    intr[2] = 1'b1;
    wait_irq(8, seen);
    checks++; if (seen !== 1'b1 || vec_addr !== 10'd1012) begin errors++; $display("FAIL nest_inner_req: irq=%b vec=%0d want 1 1012", seen, vec_addr); end
    do_ack();
    checks++; if (in_service !== 8'h14) begin errors++; $display("FAIL nest_inner_ack: in_service=%h want 14", in_service); end
    intr[6] = 1'b1;
    tick(6);
    checks++; if (irq !== 1'b0 || pending !== 8'h40) begin errors++; $display("FAIL nest_low_blocked: irq=%b pending=%h want 0 40", irq, pending); end
    do_reti();
    tick(4);
    checks++; if (irq !== 1'b0 || in_service !== 8'h10) begin errors++; $display("FAIL nest_after_reti1: irq=%b in_service=%h want 0 10", irq, in_service); end
    do_reti();
    wait_irq(4, seen);
    checks++; if (seen !== 1'b1 || vec_addr !== 10'd1020) begin errors++; $display("FAIL nest_low_served: irq=%b vec=%0d want 1 1020", seen, vec_addr); end
    do_ack();
    do_reti();
    intr = '0;
    tick(4);
  endtask

  task automatic test_mask_withdraw();
    bit seen;
    write_mask(8'hFE);
    intr[0] = 1'b1;
    tick(6);
    checks++; if (pending[0] !== 1'b1 || irq !== 1'b0) begin errors++; $display("FAIL mask_blocks: pending0=%b irq=%b want 1 0", pending[0], irq); end
    write_mask(8'hFF);
    wait_irq(4, seen);
    checks++; if (seen !== 1'b1 || vec_addr !== 10'd1008) begin errors++; $display("FAIL mask_unmask: irq=%b vec=%0d want 1 1008", seen, vec_addr); end
    do_gie_clr();
    checks++; if (irq !== 1'b0 || pending[0] !== 1'b1) begin errors++; $display("FAIL withdraw: irq=%b pending0=%b want 0 1", irq, pending[0]); end
    tick(4);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL withdraw_gie_off: irq=%b want 0", irq); end
    do_gie_set();
    wait_irq(4, seen);
    checks++; if (seen !== 1'b1 || vec_addr !== 10'd1008) begin errors++; $display("FAIL withdraw_resume: irq=%b vec=%0d want 1 1008", seen, vec_addr); end
    do_ack();
    do_reti();
    intr = '0;
    tick(4);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL no_overrun_yet: got %b want 0", overrun); end
  endtask

  task automatic test_edge_cases();
    bit seen;
    do_gie_clr();
    intr[7] = 1'b1; tick(4);
    intr[7] = 1'b0; tick(3);
    checks++; if (pending !== 8'h80 || overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre: pending=%h overrun=%b want 80 0", pending, overrun); end
    intr[7] = 1'b1; tick(4);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", overrun); end
    do_reti();
    checks++; if (spurious_reti !== 1'b1) begin errors++; $display("FAIL spurious_pulse: got %b want 1", spurious_reti); end
    tick();
    checks++; if (spurious_reti !== 1'b0) begin errors++; $display("FAIL spurious_one_cycle: got %b want 0", spurious_reti); end
    do_ack();
    checks++; if (in_service !== 8'h00 || pending !== 8'h80) begin errors++; $display("FAIL ack_idle_ignored: in_service=%h pending=%h want 00 80", in_service, pending); end
    intr[7] = 1'b0; tick(3);
    do_gie_set();
    wait_irq(4, seen);
    checks++; if (seen !== 1'b1 || vec_addr !== 10'd1022) begin errors++; $display("FAIL ack_edge_req: irq=%b vec=%0d want 1 1022", seen, vec_addr); end
    intr[7] = 1'b1; tick(2);
    do_ack();
    checks++; if (pending[7] !== 1'b1 || in_service !== 8'h80) begin errors++; $display("FAIL ack_edge_set_wins: pending7=%b in_service=%h want 1 80", pending[7], in_service); end
    do_reti();
    intr = '0;
  endtask

  task automatic test_async_reset();
    bit seen;
    wait_irq(6, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL areset_req: irq=%b want 1", seen); end
    write_mask(8'h00);
    checks++; if (irq !== 1'b1 || vec_addr !== 10'd1022) begin errors++; $display("FAIL no_retarget: irq=%b vec=%0d want 1 1022", irq, vec_addr); end
    reset = 1'b0;
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL areset_irq: got %b want 0", irq); end
    checks++; if (pending !== 8'h00 || in_service !== 8'h00 || overrun !== 1'b0 || vec_addr !== 10'd1008) begin errors++; $display("FAIL areset_state: pending=%h in_service=%h overrun=%b vec=%0d want 00 00 0 1008", pending, in_service, overrun, vec_addr); end
    tick();
    reset = 1'b1;
    intr[3] = 1'b1;
    tick(6);
    checks++; if (irq !== 1'b0 || pending !== 8'h08) begin errors++; $display("FAIL areset_gie_off: irq=%b pending=%h want 0 08", irq, pending); end
    do_gie_set();
    wait_irq(4, seen);
    checks++; if (seen !== 1'b1 || vec_addr !== 10'd1014) begin errors++; $display("FAIL areset_mask_ones: irq=%b vec=%0d want 1 1014", seen, vec_addr); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_nesting();
    test_mask_withdraw();
    test_edge_cases();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Parametrised vectored interrupt controller: the successor to the fixed 8-line interrupt-to-address decoder in the single-cycle CPU datapath. It synchronises and edge-detects `N_INTR` external request lines and keeps pending, mask and in-service state. It supports priority-ordered nesting and presents one vectored request at a time to the control unit through a request/acknowledge handshake. Its vector output feeds the PC source mux. Its `s_intr` output drives the interrupt-context flag selection and the stack context.

## Interface
- `N_INTR`, 8, number of request lines; index 0 is the highest priority.
- `PC_W`, 10, program-counter and vector width.
- `VEC_BASE`, 10'd1008, vector of channel 0.
- `VEC_STRIDE`, 2, address distance between consecutive vectors.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous active-low reset.
- `intr` in N_INTR: raw asynchronous request lines; a rising edge requests service.
- `mask_we` in 1: write strobe for the mask register.
- `mask_wd` in N_INTR: mask write data; 1 = channel enabled.
- `gie_set` in 1: global interrupt enable set (ei).
- `gie_clr` in 1: global interrupt enable clear (di).
- `ack` in 1: control unit accepts the request (pushes PC, loads `vec_addr`).
- `reti` in 1: return-from-interrupt executed.
- `irq` out 1: request to the control unit.
- `vec_addr` out PC_W: vector of the committed channel.
- `pending` out N_INTR: latched edges not yet serviced.
- `in_service` out N_INTR: channels currently in service.
- `s_intr` out 1: OR of `in_service`.
- `overrun` out 1: sticky; set when an edge arrives on an already-pending channel.
- `spurious_reti` out 1: one-cycle pulse when `reti` arrives with `in_service == 0`.

## Operation
- Each `intr` line passes through a 2-flop synchroniser plus a third flop; `edge = s2 & ~s3`.
- **Pending update:**
  - `pending[i]` is set on `edge[i]` and cleared on `ack` for the committed channel.
  - If both happen in the same cycle, set wins.
- **Eligibility:** `pending & mask`, restricted to indices strictly lower than the lowest set bit of `in_service`. All indices qualify when `in_service == 0`.
- **FSM state IDLE:**
  - Condition: `gie` is set, no `gie_clr` this cycle, and an eligible channel exists.
  - Action: latch the lowest eligible index `ch` and go to REQ.
- **FSM state REQ:**
  - `irq = 1` and `vec_addr = VEC_BASE + ch*VEC_STRIDE`, truncated to PC_W.
  - On `ack`: clear `pending[ch]`, set `in_service[ch]`, return to IDLE.
  - On `gie_clr` without `ack`: withdraw the request and return to IDLE; `pending` is kept.
  - Mask writes and new higher-priority edges do not retarget a committed request.
- **`reti`:** clears the lowest set bit of `in_service`. With `in_service == 0` it only pulses `spurious_reti`.
- **`reti` and `ack` in the same cycle:** `reti` clears first, then `ack` sets.
- **`gie_set` and `gie_clr` in the same cycle:** clear wins.
- `vec_addr` holds its last value in IDLE.

## Timing
- **Reset values:**
  - `irq`, `pending`, `in_service`, `s_intr`, `overrun`, `spurious_reti`, and the synchroniser flops are all 0.
  - `mask` is all 1; `gie` is 0; `vec_addr` is `VEC_BASE`; state is IDLE.
- Reset is asynchronous in all flops, including a reset asserted mid-REQ, which drops `irq` immediately.
- **Request latency:** `intr` high before edge 1 gives `pending` high after edge 3 and `irq` high after edge 4, provided `gie`, the mask and eligibility hold.
- `ack` is sampled at the rising edge while `irq = 1`. `irq` is low the following cycle, and `in_service`/`s_intr` update at that same edge.
- `ack` while `irq = 0` is ignored.
- The earliest possible next `irq` is one cycle after acceptance (IDLE re-evaluates), which allows immediate back-to-back nesting.
- `spurious_reti` is registered and high for exactly the cycle after the bad `reti`.

## Structure
- Shared package `intr_pkg`:
  - FSM state encoding (IDLE, REQ).
  - Default parameter constants.
  - Function `lowest_set(vector)` returning index and valid; used for both arbitration and `reti` clearing.
- One sub-module, `intr_sync`: parametrised width, 3-flop synchroniser plus rising-edge detect, async active-low reset.

## Test plan
- **Single request:**
  - Stimulus: reset, `gie_set`, raise `intr[5]`.
  - Response: `irq` after 4 edges with `vec_addr = 1018`; `ack` gives `in_service = 8'h20`, `s_intr = 1`; `reti` returns `in_service` to 0.
- **Simultaneous edges:**
  - Stimulus: `intr[3]` and `intr[1]` rise together.
  - Response: channel 1 is served first (vec 1010); after its `reti`, channel 3 is served (vec 1014).
- **Nesting:**
  - Stimulus: channel 4 in service, then `intr[2]` rises.
  - Response: `irq` with vec 1012; after `ack`, `in_service = 8'h14`.
  - Stimulus: `intr[6]` rises during that time.
  - Response: no `irq` until both `reti`s complete.
- **Mask and withdraw:**
  - Stimulus: `mask_wd = 8'hFE`, then `intr[0]` rises.
  - Response: `pending[0] = 1`, no `irq`; unmask gives `irq`.
  - Stimulus: `gie_clr` while in REQ.
  - Response: `irq` drops next cycle and `pending[0]` stays 1.
- **Edge cases:**
  - Stimulus: second edge on an already-pending channel.
  - Response: `overrun = 1`.
  - Stimulus: `reti` at idle.
  - Response: one-cycle `spurious_reti`.
  - Stimulus: `ack` coincident with a new edge on the same channel.
  - Response: `pending` stays 1.
- **Asynchronous reset:**
  - Stimulus: `reset` asserted low mid-REQ.
  - Response: `irq` is 0 before the next clock edge, all state is at its reset value, and the mask reads all 1.
